// File: rtl/exe_alu_pipe.sv
// rtl/exe_alu_pipe.sv - single-issue ALU with registered result, status flags and iterative multiplier
// Non-MUL ops complete at the acceptance edge; MUL runs a WIDTH-cycle shift-add before registering.
module exe_alu_pipe #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       exe_cmd,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   input  logic             s_flag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic [3:0]       sr,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t           state;
   logic             rst_done;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [CW-1:0]    mul_cnt;
   logic             mul_s;

   logic             accept;
   logic             is_mul;
   logic             is_sub;
   logic             cin;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             c_new;
   logic             v_new;
   logic             mul_last;
   logic [WIDTH-1:0] mul_prod;

   // rst_done keeps in_ready low until the first edge after reset release.
   assign in_ready = rst_done && (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (MUL_EN != 0) && (exe_cmd == OP_MUL);
   assign mul_last = (state == ST_MUL) && (mul_cnt == CW'(WIDTH - 1));
   assign mul_prod = mul_acc + (mul_b[0] ? mul_a : '0);

   // Subtraction is a + ~b + cin, so the carry out is directly NOT borrow.
   always_comb begin
      is_sub = (exe_cmd == OP_SUB) || (exe_cmd == OP_SBC);
      op_b   = is_sub ? ~val2 : val2;
      cin    = (exe_cmd == OP_ADD) ? 1'b0 : (exe_cmd == OP_SUB) ? 1'b1 : sr[1];
      sum    = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
      res    = '0;
      c_new  = sr[1];
      v_new  = sr[0];
      case (exe_cmd)
         OP_MOV: res = val2;
         OP_MVN: res = ~val2;
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            res   = sum[WIDTH-1:0];
            c_new = sum[WIDTH];
            v_new = (val1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
         end
         OP_AND: res = val1 & val2;
         OP_ORR: res = val1 | val2;
         OP_EOR: res = val1 ^ val2;
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rst_done   <= 1'b0;
         out_valid  <= 1'b0;
         alu_result <= '0;
         sr         <= 4'b0000;
         busy       <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_acc    <= '0;
         mul_cnt    <= '0;
         mul_s      <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state   <= ST_MUL;
                     busy    <= 1'b1;
                     mul_a   <= val1;
                     mul_b   <= val2;
                     mul_acc <= '0;
                     mul_cnt <= '0;
                     mul_s   <= s_flag;
                  end else begin
                     alu_result <= res;
                     out_valid  <= 1'b1;
                     if (s_flag) begin
                        sr <= {res[WIDTH-1], (res == '0), c_new, v_new};
                     end
                  end
               end
            end
            ST_MUL: begin
               mul_acc <= mul_prod;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               mul_cnt <= mul_cnt + CW'(1);
               if (mul_last) begin
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  alu_result <= mul_prod;
                  out_valid  <= 1'b1;
                  mul_acc    <= '0;
                  mul_cnt    <= '0;
                  if (mul_s) begin
                     sr[3:2] <= {mul_prod[WIDTH-1], (mul_prod == '0)};
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/exe_alu_pipe.md
EXE_ALU_PIPE -- requirements
Module: exe_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width; legal range 8 to 64.
REQ-002 Parameter MUL_EN, default 1, includes the iterative multiplier when 1.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  an operation is presented.
REQ-006 in_ready  output  1  the block can accept an operation this cycle.
REQ-007 exe_cmd  input  4  operation code, see REQ-013.
REQ-008 val1, val2  input  WIDTH each  operands.
REQ-009 s_flag  input  1  when 1, the operation updates sr.
REQ-010 out_valid  output  1  alu_result holds a completed operation.
REQ-011 out_ready  input  1  the consumer takes the result.
REQ-012 alu_result  output  WIDTH  registered result; sr  output  4  registered status {N,Z,C,V}, bits 3 to 0; busy  output  1  a multiply is in progress.

Function
REQ-013 Encoding:
- 0001 MOV = val2; 1001 MVN = ~val2
- 0010 ADD = val1+val2; 0011 ADC = val1+val2+C
- 0100 SUB = val1-val2; 0101 SBC = val1-val2-~C
- 0110 AND; 0111 ORR; 1000 EOR
- 1010 MUL = low WIDTH bits of val1*val2
- all other codes give result 0.
REQ-014 C used by ADC/SBC SHALL be sr[1] as registered at the acceptance edge; there is no external carry input.
REQ-015 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; exe_cmd, val1, val2 and s_flag are sampled at that edge only.
REQ-016 in_ready SHALL be 1 when state is IDLE and (out_valid=0 or out_ready=1); combinational.
REQ-017 Non-MUL ops: alu_result and out_valid=1 SHALL be registered at the acceptance edge (latency 1); back-to-back acceptance at one op per cycle SHALL be supported.
REQ-018 State machine:
- IDLE to MUL on acceptance of MUL with MUL_EN=1.
- MUL runs a shift-add for WIDTH cycles with busy=1 and in_ready=0.
- MUL to IDLE on the WIDTH-th cycle, registering the product with out_valid=1.
REQ-019 With MUL_EN=0, code 1010 SHALL be treated as an undefined code.
REQ-020 out_valid, alu_result and sr SHALL hold while out_valid=1 and out_ready=0.
REQ-021 out_valid SHALL clear on an edge with out_ready=1 unless a new result is registered at that same edge.
REQ-022 Flags when s_flag=1, updated at the edge the result is registered:
- N = result MSB; Z = (result == 0).
- ADD/ADC: C = carry out of bit WIDTH-1; V = signed overflow.
- SUB/SBC: C = NOT borrow; V = signed overflow.
- MOV, MVN, AND, ORR, EOR, MUL and undefined codes: C and V unchanged.
REQ-023 With s_flag=0, sr SHALL be unchanged.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 With rst_n=0, at any time including mid-multiply, the block SHALL asynchronously return to IDLE.
REQ-026 Reset values: alu_result=0, sr=4'b0000, out_valid=0, busy=0, multiplier accumulator and counter=0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and SHALL follow REQ-016 from the first edge after release.

Verification (WIDTH=32)
REQ-028 ADD 13+15, s_flag=1 -> alu_result=28, sr=0000, out_valid one cycle after acceptance.
REQ-029 SUB 13-15, s_flag=1 -> alu_result=0xFFFFFFFE, sr=1000.
- Then SBC 13-15 -> 0xFFFFFFFD, since C=0.
REQ-030 ADD 0xFFFFFFFF+1, s_flag=1 -> 0, sr=0110.
- Then ADC 0+0, s_flag=0 -> 1; sr stays 0110.
- Then ADD 0x7FFFFFFF+1, s_flag=1 -> sr=1001.
REQ-031 MUL 13*15 -> busy=1 and in_ready=0 for 32 cycles, then alu_result=195 with out_valid=1.
- in_valid pulses during busy are ignored.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles after MVN 15.
- alu_result=0xFFFFFFF0 holds and in_ready=0 throughout.
- Raising out_ready completes the transfer; a new op is accepted at that same edge.
REQ-033 Assert rst_n=0 at cycle 10 of a MUL -> all outputs reach reset values immediately.
- After release, ADD 2+3 -> 5.
